// File: rtl/fpdiv_round.sv
// fpdiv_round: two-stage binary32 round/pack stage for a Goldschmidt divide/sqrt core
module fpdiv_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        round_mode,
  input  logic [1:0]  op,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [25:0] qd,
  input  logic        r_sign,
  input  logic        r_zero,
  input  logic [1:0]  special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  logic s2_adv, in_fire, sticky_r, hi;
  logic [25:0] q_adj;
  logic s1_v, s1_rm, s1_sign, s1_guard, s1_sticky;
  logic [1:0] s1_sp;
  logic [23:0] s1_mant;
  logic signed [10:0] s1_exp;
  logic inc, carry, ovf, unf;
  logic [22:0] frac;
  logic signed [10:0] exp_r;
  logic [31:0] res_n;
  logic [2:0] flg_n;
  assign s2_adv = !out_valid | out_ready;
  assign in_ready = !reset & (!s1_v | s2_adv);
  assign in_fire = in_valid & in_ready;
  assign q_adj = qd - {25'd0, r_sign};
  assign sticky_r = !r_zero | r_sign;
  assign hi = q_adj[25];
  always_ff @(posedge clk) begin
    if (reset) s1_v <= 1'b0;
    else if (in_fire) s1_v <= 1'b1;
    else if (s2_adv) s1_v <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_rm <= round_mode;
      s1_sign <= sign_in & !(op == 2'b01 && special != 2'b01);
      s1_sp <= special;
      s1_mant <= hi ? q_adj[25:2] : q_adj[24:1];
      s1_guard <= hi ? q_adj[1] : q_adj[0];
      s1_sticky <= hi ? (q_adj[0] | sticky_r) : sticky_r;
      s1_exp <= {exp_in[9], exp_in} - {10'd0, !hi};
    end
  end
  // a carry out of the 24-bit significand leaves the fraction field at zero
  assign inc = !s1_rm & s1_guard & (s1_sticky | s1_mant[0]);
  assign carry = inc & (&s1_mant);
  assign frac = s1_mant[22:0] + {22'd0, inc};
  assign exp_r = s1_exp + {10'd0, carry};
  assign ovf = exp_r >= 11'sd255;
  assign unf = exp_r <= 11'sd0;
  always_comb begin
    res_n = s1_sp == 2'b11 ? 32'h7FC00000 :
            s1_sp == 2'b10 ? {s1_sign, 31'h7F800000} :
            s1_sp == 2'b01 ? {s1_sign, 31'd0} :
            ovf ? {s1_sign, s1_rm ? 31'h7F7FFFFF : 31'h7F800000} :
            unf ? {s1_sign, 31'd0} : {s1_sign, exp_r[7:0], frac};
    flg_n = s1_sp != 2'b00 ? 3'b000 : ovf ? 3'b101 : unf ? 3'b011 : {2'b00, s1_guard | s1_sticky};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result <= 32'd0;
      flags <= 3'd0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        result <= res_n;
        flags <= flg_n;
      end
    end
  end
endmodule

// File: tb/tb_fpdiv_round.sv
// tb_fpdiv_round: randomized and directed checks of fpdiv_round against an arithmetic reference model
module tb_fpdiv_round;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, round_mode, sign_in, r_sign, r_zero, out_valid, out_ready;
  logic [1:0] op, special;
  logic [9:0] exp_in;
  logic [25:0] qd;
  logic [31:0] result;
  logic [2:0] flags;
  int n_tests = 0;
  int n_fail = 0;
  logic [34:0] expq[$];

  typedef struct packed {
    bit rm; bit [1:0] op; bit sg; bit [9:0] e; bit [25:0] q; bit rs; bit rz; bit [1:0] sp;
  } vec_t;

  fpdiv_round dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .round_mode(round_mode), .op(op), .sign_in(sign_in), .exp_in(exp_in), .qd(qd),
    .r_sign(r_sign), .r_zero(r_zero), .special(special), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // value-level model: round by comparing the discarded remainder against half an ulp
  function automatic logic [34:0] model(input vec_t v);
    logic s;
    int unsigned qa, keep, rem, half;
    int ex;
    bit stk, up, inx;
    s = (v.op == 2'b01 && v.sp != 2'b01) ? 1'b0 : v.sg;
    if (v.sp == 2'b01) return {3'b000, s, 31'd0};
    if (v.sp == 2'b10) return {3'b000, s, 31'h7F800000};
    if (v.sp == 2'b11) return {3'b000, 32'h7FC00000};
    qa = (32'(v.q) - 32'(v.rs)) & 32'h3FFFFFF;
    stk = !v.rz || v.rs;
    ex = int'($signed(v.e));
    if (qa >= 32'h2000000) begin
      keep = qa / 4; rem = qa % 4; half = 2;
    end else begin
      keep = qa / 2; rem = qa % 2; half = 1; ex = ex - 1;
    end
    inx = rem != 0 || stk;
    up = !v.rm && (rem > half || (rem == half && (stk || keep % 2 == 1)));
    keep = keep + 32'(up);
    if (keep >= 32'h1000000) begin
      keep = 32'h800000; ex = ex + 1;
    end
    if (ex >= 255) return {3'b101, s, v.rm ? 31'h7F7FFFFF : 31'h7F800000};
    if (ex <= 0) return {3'b011, s, 31'd0};
    return {2'b00, inx, s, 8'(ex), keep[22:0]};
  endfunction

  function automatic vec_t mk(bit m, bit [1:0] o, bit g, bit [9:0] e, bit [25:0] q, bit s, bit z, bit [1:0] p);
    vec_t v;
    v.rm = m; v.op = o; v.sg = g; v.e = e; v.q = q; v.rs = s; v.rz = z; v.sp = p;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.rm = 1'($urandom % 2);
    v.op = 2'($urandom % 4);
    v.sg = 1'($urandom % 2);
    v.sp = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    case ($urandom % 4)
      0: v.e = 10'($urandom_range(0, 1023));
      1: v.e = 10'($urandom_range(0, 6));
      2: v.e = 10'($urandom_range(250, 258));
      default: v.e = 10'($urandom_range(100, 150));
    endcase
    v.q = ($urandom % 8 == 0) ? 26'({$urandom_range(0, 1), 24'hFFFFFF, 1'b0} | 26'($urandom % 4))
                              : 26'($urandom_range(32'h1000000, 32'h3FFFFFF));
    v.rz = 1'($urandom % 2);
    v.rs = v.rz ? 1'b0 : 1'($urandom % 2);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    round_mode = v.rm; op = v.op; sign_in = v.sg; exp_in = v.e;
    qd = v.q; r_sign = v.rs; r_zero = v.rz; special = v.sp;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    apply(mk(0, 0, 0, 10'd127, 26'h2000000, 0, 1, 0));
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
    n_tests++; if (flags !== 3'd0) begin n_fail++; $display("FAIL reset_flags got=%b want=000", flags); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    vec_t dv[19];
    logic [34:0] de[19];
    dv[0]  = mk(0, 0, 0, 10'd127, 26'h2000000, 0, 1, 0); de[0]  = {3'b000, 32'h3F800000};
    dv[1]  = mk(0, 0, 0, 10'd127, 26'h2000002, 0, 1, 0); de[1]  = {3'b001, 32'h3F800000};
    dv[2]  = mk(0, 0, 0, 10'd127, 26'h2000006, 0, 1, 0); de[2]  = {3'b001, 32'h3F800002};
    dv[3]  = mk(0, 0, 0, 10'd127, 26'h2000000, 1, 0, 0); de[3]  = {3'b001, 32'h3F800000};
    dv[4]  = mk(1, 0, 0, 10'd127, 26'h2000000, 1, 0, 0); de[4]  = {3'b001, 32'h3F7FFFFF};
    dv[5]  = mk(0, 0, 0, 10'd255, 26'h2000000, 0, 1, 0); de[5]  = {3'b101, 32'h7F800000};
    dv[6]  = mk(1, 0, 0, 10'd255, 26'h2000000, 0, 1, 0); de[6]  = {3'b101, 32'h7F7FFFFF};
    dv[7]  = mk(0, 0, 0, 10'd0,   26'h1000000, 0, 1, 0); de[7]  = {3'b011, 32'h00000000};
    dv[8]  = mk(0, 0, 1, 10'd127, 26'h2000000, 0, 1, 0); de[8]  = {3'b000, 32'hBF800000};
    dv[9]  = mk(0, 1, 1, 10'd127, 26'h2000000, 0, 1, 0); de[9]  = {3'b000, 32'h3F800000};
    dv[10] = mk(0, 1, 1, 10'd127, 26'h2000000, 0, 1, 1); de[10] = {3'b000, 32'h80000000};
    dv[11] = mk(0, 1, 1, 10'd0,   26'h0,       0, 1, 2); de[11] = {3'b000, 32'h7F800000};
    dv[12] = mk(0, 0, 1, 10'd0,   26'h0,       0, 1, 2); de[12] = {3'b000, 32'hFF800000};
    dv[13] = mk(0, 0, 1, 10'd0,   26'h0,       0, 1, 3); de[13] = {3'b000, 32'h7FC00000};
    dv[14] = mk(1, 0, 1, 10'd254, 26'h3FFFFFF, 0, 1, 0); de[14] = {3'b001, 32'hFF7FFFFF};
    dv[15] = mk(0, 0, 1, 10'd254, 26'h3FFFFFF, 0, 1, 0); de[15] = {3'b101, 32'hFF800000};
    dv[16] = mk(0, 0, 0, 10'd2,   26'h1000000, 0, 1, 0); de[16] = {3'b000, 32'h00800000};
    dv[17] = mk(0, 0, 0, 10'd1,   26'h1000000, 0, 1, 0); de[17] = {3'b011, 32'h00000000};
    dv[18] = mk(0, 0, 1, 10'h3FB, 26'h2000000, 0, 1, 0); de[18] = {3'b011, 32'h80000000};
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      apply(dv[i]); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
      n_tests++; if ({flags, result} !== de[i])
        begin n_fail++; $display("FAIL dir%0d_value got=%b/%h want=%b/%h", i, flags, result, de[i][34:32], de[i][31:0]); end
    end
  endtask

  task automatic test_throughput();
    logic [34:0] e[8];
    vec_t v;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c >= 2) begin
        n_tests++; if (out_valid !== 1'b1 || {flags, result} !== e[c-2])
          begin n_fail++; $display("FAIL thru%0d got=%b %b/%h want=1 %b/%h", c - 2, out_valid, flags, result, e[c-2][34:32], e[c-2][31:0]); end
      end
      in_valid = c < 8;
      if (c < 8) begin
        v = rand_vec(); apply(v); e[c] = model(v);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL thru_in_ready%0d got=%b want=1", c, in_ready); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    vec_t v[3];
    int k = 0;
    int got = 0;
    logic [34:0] stall, w;
    expq.delete();
    for (int i = 0; i < 3; i++) v[i] = rand_vec();
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (c == 2) stall = {flags, result};
      if (c >= 3 && c <= 5) begin
        n_tests++; if (out_valid !== 1'b1 || {flags, result} !== stall)
          begin n_fail++; $display("FAIL b2b_stable c=%0d got=%b %h want=1 %h", c, out_valid, result, stall[31:0]); end
      end
      if (c == 5) begin
        n_tests++; if (k !== 2) begin n_fail++; $display("FAIL b2b_accepted got=%0d want=2", k); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got=%b want=0", in_ready); end
      end
      out_ready = c >= 5;
      if (out_valid && out_ready) begin
        w = expq.pop_front(); got++;
        n_tests++; if ({flags, result} !== w)
          begin n_fail++; $display("FAIL b2b_order%0d got=%b/%h want=%b/%h", got, flags, result, w[34:32], w[31:0]); end
      end
      in_valid = k < 3;
      if (k < 3) apply(v[k]);
      #1;
      if (in_valid && in_ready) begin expq.push_back(model(v[k])); k++; end
    end
    in_valid = 1'b0;
    n_tests++; if (got !== 3) begin n_fail++; $display("FAIL b2b_drain got=%0d want=3", got); end
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [34:0] held_val, w;
    vec_t v;
    expq.delete();
    while ((acc < 600 || expq.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        n_tests++; if (out_valid !== 1'b1 || {flags, result} !== held_val)
          begin n_fail++; $display("FAIL rand_hold got=%b %b/%h want=1 %b/%h", out_valid, flags, result, held_val[34:32], held_val[31:0]); end
      end
      out_ready = ($urandom % 4) != 0;
      if (out_valid && out_ready) begin
        n_tests++;
        if (expq.size() == 0) begin n_fail++; $display("FAIL rand_extra got=%h want=none", result); end
        else begin
          w = expq.pop_front();
          if ({flags, result} !== w) begin n_fail++; $display("FAIL rand_value got=%b/%h want=%b/%h", flags, result, w[34:32], w[31:0]); end
        end
      end
      held = out_valid && !out_ready;
      held_val = {flags, result};
      v = rand_vec(); apply(v);
      in_valid = acc < 600 && ($urandom % 4) != 0;
      #1;
      if (in_valid && in_ready) begin expq.push_back(model(v)); acc++; end
    end
    in_valid = 1'b0;
    n_tests++; if (acc != 600 || expq.size() != 0)
      begin n_fail++; $display("FAIL rand_timeout got=%0d/%0d want=600/0", acc, expq.size()); end
  endtask

  task automatic test_reset_midflight();
    vec_t v;
    logic [34:0] w;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      apply(rand_vec());
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL rstmid_result got=%h want=0", result); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=0", in_ready); end
    reset = 1'b0; out_ready = 1'b1;
    v = rand_vec(); apply(v); w = model(v);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale got=%b want=0", out_valid); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || {flags, result} !== w)
      begin n_fail++; $display("FAIL rstmid_fresh got=%b %b/%h want=1 %b/%h", out_valid, flags, result, w[34:32], w[31:0]); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_throughput();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
